// File: rtl/mac_filter_ctrl.sv
// mac_filter_ctrl: per-frame sequencer for a bank of streaming MAC comparators.
// Define MAC_FILTER_PROMISC_EN to add the promisc input (forces accept at decision time).
module mac_filter_ctrl #(
    parameter int NUM_MACS     = 4,
    parameter int MATCH_WINDOW = 4,
    parameter int MATCH_LAT    = 2,
    localparam int IW = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [IW-1:0]          cfg_addr,
    input  logic [47:0]            cfg_mac,
    input  logic                   cfg_en,
    input  logic                   frame_start,
    input  logic                   data_valid,
    input  logic                   frame_end,
    input  logic [31:0]            data_in,
    output logic                   cmp_clear,
    output logic [31:0]            cmp_data,
    output logic [48*NUM_MACS-1:0] cmp_mac,
    input  logic [NUM_MACS-1:0]    cmp_match,
`ifdef MAC_FILTER_PROMISC_EN
    input  logic                   promisc,
`endif
    output logic                   decision_valid,
    output logic                   accept,
    output logic [IW-1:0]          hit_idx,
    output logic                   win_err,
    output logic                   busy,
    input  logic                   stat_clr,
    output logic [15:0]            acc_cnt,
    output logic [15:0]            drop_cnt,
    output logic [2:0]             dbg_state
);
    // Stream handshake: data_valid qualifies data_in and frame_end; frame_start marks a
    // valid first word. There is no backpressure; decision_valid is a one-cycle pulse.

    localparam int WCW = $clog2(MATCH_WINDOW + 1);
    localparam int LCW = (MATCH_LAT > 1) ? $clog2(MATCH_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_WAIT   = 3'd2,
        S_DECIDE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t               state, state_nx;
    logic [WCW-1:0]       word_cnt, word_cnt_nx;
    logic [LCW-1:0]       lat_cnt, lat_cnt_nx;
    logic                 werr, werr_nx;
    logic                 fend, fend_nx;
    logic                 do_decide, do_abort, acc_dec;
    logic [IW-1:0]        hit_nx;
    logic [NUM_MACS-1:0]  masked;
    logic [NUM_MACS-1:0]  en_snap;
    logic [48*NUM_MACS-1:0] tbl_mac, tbl_mac_nx;
    logic [NUM_MACS-1:0]  tbl_en, tbl_en_nx;
    logic [15:0]          acc_cnt_nx, drop_cnt_nx;

    // Table with the current write folded in, so a snapshot taken this cycle sees it.
    always_comb begin
        tbl_mac_nx = tbl_mac;
        tbl_en_nx  = tbl_en;
        if (cfg_we) begin
            tbl_mac_nx[48*cfg_addr +: 48] = cfg_mac;
            tbl_en_nx[cfg_addr]           = cfg_en;
        end
    end

    assign masked = cmp_match & en_snap;

    always_comb begin
        hit_nx = '0;
        for (int i = NUM_MACS - 1; i >= 0; i--) begin
            if (masked[i]) hit_nx = IW'(i);
        end
    end

`ifdef MAC_FILTER_PROMISC_EN
    assign acc_dec = promisc || ((|masked) && !werr);
`else
    assign acc_dec = (|masked) && !werr;
`endif

    always_comb begin
        state_nx    = state;
        word_cnt_nx = word_cnt;
        lat_cnt_nx  = lat_cnt;
        werr_nx     = werr;
        fend_nx     = fend;
        do_decide   = 1'b0;
        do_abort    = 1'b0;
        if (frame_start) begin
            // A new frame always wins, including over a pending decision.
            do_abort    = (state != S_IDLE);
            word_cnt_nx = WCW'(1);
            lat_cnt_nx  = '0;
            fend_nx     = data_valid && frame_end;
            werr_nx     = 1'b0;
            if (MATCH_WINDOW == 1) begin
                state_nx = S_WAIT;
            end else if (data_valid && frame_end) begin
                werr_nx  = 1'b1;
                state_nx = S_WAIT;
            end else begin
                state_nx = S_SCAN;
            end
        end else begin
            case (state)
                S_IDLE: ;
                S_SCAN: begin
                    lat_cnt_nx = '0;
                    if (!data_valid) begin
                        werr_nx  = 1'b1;
                        state_nx = S_WAIT;
                    end else begin
                        word_cnt_nx = word_cnt + 1'b1;
                        if (frame_end) fend_nx = 1'b1;
                        if (word_cnt == WCW'(MATCH_WINDOW - 1)) begin
                            state_nx = S_WAIT;
                        end else if (frame_end) begin
                            werr_nx  = 1'b1;
                            state_nx = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (data_valid && frame_end) fend_nx = 1'b1;
                    if (lat_cnt == LCW'(MATCH_LAT - 1)) state_nx = S_DECIDE;
                    else lat_cnt_nx = lat_cnt + 1'b1;
                end
                S_DECIDE: begin
                    do_decide = 1'b1;
                    state_nx  = (fend || (data_valid && frame_end)) ? S_IDLE : S_HOLD;
                end
                S_HOLD: begin
                    if (data_valid && frame_end) state_nx = S_IDLE;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Saturating statistics; clear beats a coincident increment.
    always_comb begin
        acc_cnt_nx  = acc_cnt;
        drop_cnt_nx = drop_cnt;
        if (stat_clr) begin
            acc_cnt_nx  = '0;
            drop_cnt_nx = '0;
        end else begin
            if (do_decide && acc_dec && acc_cnt != 16'hFFFF)
                acc_cnt_nx = acc_cnt + 16'd1;
            if (((do_decide && !acc_dec) || do_abort) && drop_cnt != 16'hFFFF)
                drop_cnt_nx = drop_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            word_cnt       <= '0;
            lat_cnt        <= '0;
            werr           <= 1'b0;
            fend           <= 1'b0;
            tbl_mac        <= '0;
            tbl_en         <= '0;
            en_snap        <= '0;
            cmp_mac        <= '0;
            cmp_clear      <= 1'b0;
            cmp_data       <= '0;
            decision_valid <= 1'b0;
            accept         <= 1'b0;
            hit_idx        <= '0;
            win_err        <= 1'b0;
            acc_cnt        <= '0;
            drop_cnt       <= '0;
        end else begin
            state          <= state_nx;
            word_cnt       <= word_cnt_nx;
            lat_cnt        <= lat_cnt_nx;
            werr           <= werr_nx;
            fend           <= fend_nx;
            tbl_mac        <= tbl_mac_nx;
            tbl_en         <= tbl_en_nx;
            cmp_clear      <= frame_start;
            cmp_data       <= data_valid ? data_in : 32'd0;
            decision_valid <= do_decide;
            acc_cnt        <= acc_cnt_nx;
            drop_cnt       <= drop_cnt_nx;
            if (frame_start) begin
                cmp_mac <= tbl_mac_nx;
                en_snap <= tbl_en_nx;
            end
            if (do_decide) begin
                accept  <= acc_dec;
                hit_idx <= hit_nx;
                win_err <= werr;
            end
        end
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mac_filter_ctrl.sv
// Self-checking bench for mac_filter_ctrl: directed scenarios plus randomized frames
// checked against a frame-level reference model.
module tb_mac_filter_ctrl;
    localparam int NUM_MACS = 4;
    localparam int W        = 4;
    localparam int L        = 2;
    localparam int IW       = 2;
    localparam int EW       = IW + 2;
    localparam int LATENCY  = W + L + 1;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_we;
    logic [IW-1:0]          cfg_addr;
    logic [47:0]            cfg_mac;
    logic                   cfg_en;
    logic                   frame_start, data_valid, frame_end;
    logic [31:0]            data_in;
    logic                   cmp_clear;
    logic [31:0]            cmp_data;
    logic [48*NUM_MACS-1:0] cmp_mac;
    logic [NUM_MACS-1:0]    cmp_match;
    logic                   decision_valid, accept, win_err, busy, stat_clr;
    logic [IW-1:0]          hit_idx;
    logic [15:0]            acc_cnt, drop_cnt;
    logic [2:0]             dbg_state;

    mac_filter_ctrl #(.NUM_MACS(NUM_MACS), .MATCH_WINDOW(W), .MATCH_LAT(L)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_mac(cfg_mac), .cfg_en(cfg_en),
        .frame_start(frame_start), .data_valid(data_valid), .frame_end(frame_end),
        .data_in(data_in),
        .cmp_clear(cmp_clear), .cmp_data(cmp_data), .cmp_mac(cmp_mac),
        .cmp_match(cmp_match),
`ifdef MAC_FILTER_PROMISC_EN
        .promisc(1'b0),
`endif
        .decision_valid(decision_valid), .accept(accept), .hit_idx(hit_idx),
        .win_err(win_err), .busy(busy), .stat_clr(stat_clr),
        .acc_cnt(acc_cnt), .drop_cnt(drop_cnt), .dbg_state(dbg_state)
    );

    // Clock and cycle stamp
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int start_cyc = 0;

    // Reference model state
    logic [47:0]         m_mac [NUM_MACS];
    logic [NUM_MACS-1:0] m_en;
    int                  exp_acc, exp_drop;
    logic [EW-1:0]       exp_q[$];

    // Decision recorder
    logic [EW-1:0] obs_q[$];
    int            obs_cyc_q[$];
    always @(negedge clk) begin
        if (decision_valid === 1'b1) begin
            obs_q.push_back({win_err, accept, hit_idx});
            obs_cyc_q.push_back(cyc);
        end
    end

    function automatic logic [EW-1:0] model_decision(input logic [NUM_MACS-1:0] match,
                                                     input logic [NUM_MACS-1:0] en,
                                                     input bit werr);
        logic [IW-1:0] hit;
        bit any;
        hit = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_MACS; i++) begin
            if (match[i] && en[i]) begin
                hit = IW'(i);
                any = 1'b1;
                break;
            end
        end
        return {werr, any && !werr, hit};
    endfunction

    function automatic bit model_werr(input int len, input int gap);
        return (len < W) || (gap >= 1 && gap < W && gap < len);
    endfunction

    function automatic void model_count(input bit acc);
        if (acc) exp_acc = (exp_acc < 65535) ? exp_acc + 1 : 65535;
        else exp_drop = (exp_drop < 65535) ? exp_drop + 1 : 65535;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_MACS; i++) m_mac[i] = '0;
        m_en = '0;
        exp_acc = 0;
        exp_drop = 0;
    endfunction

    // Driver tasks
    task automatic cfg_write(input int a, input logic [47:0] m, input bit e);
        cfg_we = 1'b1; cfg_addr = IW'(a); cfg_mac = m; cfg_en = e;
        @(negedge clk);
        cfg_we = 1'b0;
        m_mac[a] = m;
        m_en[a] = e;
    endtask

    // gap: one idle cycle inserted before word index gap (-1 for none)
    task automatic send_frame(input int len, input int gap);
        for (int w = 0; w < len; w++) begin
            if (w == gap) begin
                data_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
                @(negedge clk);
            end
            data_valid = 1'b1; frame_start = (w == 0); frame_end = (w == len - 1);
            data_in = $urandom;
            if (w == 0) start_cyc = cyc;
            @(negedge clk);
        end
        data_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0; data_in = '0;
    endtask

    task automatic wait_decision(output bit got, output logic [EW-1:0] obs, output int oc);
        got = 1'b0; obs = '0; oc = 0;
        for (int t = 0; t < 40 && !got; t++) begin
            if (obs_q.size() > 0) begin
                obs = obs_q.pop_front();
                oc = obs_cyc_q.pop_front();
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 40 && busy !== 1'b0; t++) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL idle_timeout: busy=%b required 0", busy); end
        @(negedge clk);
    endtask

    // Scenarios
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        n_cmp++;
        if ({cmp_clear, cmp_data, decision_valid, accept, hit_idx, win_err} !== '0) begin
            n_err++; $display("FAIL reset_outputs: clr=%b data=%h dv=%b acc=%b hit=%0d werr=%b required all 0",
                              cmp_clear, cmp_data, decision_valid, accept, hit_idx, win_err);
        end
        n_cmp++;
        if (cmp_mac !== '0) begin n_err++; $display("FAIL reset_cmp_mac: got %h required 0", cmp_mac); end
        n_cmp++;
        if ({busy, dbg_state} !== 4'd0) begin n_err++; $display("FAIL reset_state: busy=%b state=%0d required 0/0", busy, dbg_state); end
        n_cmp++;
        if ({acc_cnt, drop_cnt} !== 32'd0) begin n_err++; $display("FAIL reset_counters: acc=%0d drop=%0d required 0/0", acc_cnt, drop_cnt); end
    endtask

    task automatic test_hit();
        logic [EW-1:0] e, obs;
        bit got;
        int oc;
        cfg_write(2, 48'hA1B2C3D4E5F6, 1'b1);
        cmp_match = 4'b0100;
        e = model_decision(cmp_match, m_en, 1'b0);
        exp_q.push_back(e);
        model_count(e[EW-2]);
        send_frame(4, -1);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL hit_busy: got %b required 1", busy); end
        n_cmp++;
        if (cmp_mac[2*48 +: 48] !== m_mac[2]) begin n_err++; $display("FAIL hit_cmp_mac: got %h required %h", cmp_mac[2*48 +: 48], m_mac[2]); end
        wait_decision(got, obs, oc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL hit_timeout: no decision, required one"); end
        n_cmp++;
        if (obs !== e) begin n_err++; $display("FAIL hit_decision: got %b required %b", obs, e); end
        n_cmp++;
        if (oc - start_cyc != LATENCY) begin n_err++; $display("FAIL hit_latency: got %0d required %0d", oc - start_cyc, LATENCY); end
        n_cmp++;
        if (acc_cnt !== 16'(exp_acc)) begin n_err++; $display("FAIL hit_acc_cnt: got %0d required %0d", acc_cnt, exp_acc); end
        wait_idle();
        n_cmp++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL hit_single_pulse: %0d extra decisions, required 0", obs_q.size()); end
    endtask

    task automatic test_priority();
        logic [EW-1:0] e, obs;
        bit got;
        int oc;
        logic [NUM_MACS-1:0] pats [2];
        pats[0] = 4'b1010;
        pats[1] = 4'b0010;
        cfg_write(1, 48'h0000_1111_2222, 1'b0);
        cfg_write(3, 48'h0000_3333_4444, 1'b1);
        for (int p = 0; p < 2; p++) begin
            cmp_match = pats[p];
            e = model_decision(cmp_match, m_en, 1'b0);
            model_count(e[EW-2]);
            exp_q.push_back(e);
            send_frame(4, -1);
            wait_decision(got, obs, oc);
            e = exp_q.pop_front();
            n_cmp++;
            if (!got || obs !== e) begin n_err++; $display("FAIL priority_%0d: got %b (seen=%b) required %b", p, obs, got, e); end
            n_cmp++;
            if (drop_cnt !== 16'(exp_drop)) begin n_err++; $display("FAIL priority_drop_%0d: got %0d required %0d", p, drop_cnt, exp_drop); end
            wait_idle();
        end
    endtask

    task automatic test_window_break();
        logic [EW-1:0] e, obs;
        bit got;
        int oc;
        cmp_match = 4'b1000;
        e = model_decision(cmp_match, m_en, model_werr(5, 2));
        model_count(e[EW-2]);
        exp_q.push_back(e);
        send_frame(5, 2);
        wait_decision(got, obs, oc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || obs !== e) begin n_err++; $display("FAIL window_break: got %b (seen=%b) required %b", obs, got, e); end
        n_cmp++;
        if (drop_cnt !== 16'(exp_drop)) begin n_err++; $display("FAIL window_break_drop: got %0d required %0d", drop_cnt, exp_drop); end
        wait_idle();
    endtask

    task automatic test_snapshot();
        logic [EW-1:0] e, obs;
        logic [47:0] snap0;
        bit got;
        int oc;
        cfg_write(0, 48'h0A0B_0C0D_0E0F, 1'b1);
        cmp_match = 4'b0001;
        snap0 = m_mac[0];
        e = model_decision(cmp_match, m_en, 1'b0);
        model_count(e[EW-2]);
        exp_q.push_back(e);
        fork
            send_frame(4, -1);
            begin
                repeat (2) @(negedge clk);
                cfg_write(0, 48'hFEDC_BA98_7654, 1'b0);
            end
        join
        n_cmp++;
        if (cmp_mac[47:0] !== snap0) begin n_err++; $display("FAIL snapshot_hold: got %h required %h", cmp_mac[47:0], snap0); end
        wait_decision(got, obs, oc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || obs !== e) begin n_err++; $display("FAIL snapshot_decision: got %b (seen=%b) required %b", obs, got, e); end
        wait_idle();
        e = model_decision(cmp_match, m_en, 1'b0);
        model_count(e[EW-2]);
        exp_q.push_back(e);
        send_frame(4, -1);
        n_cmp++;
        if (cmp_mac[47:0] !== m_mac[0]) begin n_err++; $display("FAIL snapshot_new: got %h required %h", cmp_mac[47:0], m_mac[0]); end
        wait_decision(got, obs, oc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || obs !== e) begin n_err++; $display("FAIL snapshot_decision2: got %b (seen=%b) required %b", obs, got, e); end
        wait_idle();
    endtask

    task automatic test_abort();
        logic [EW-1:0] e, obs;
        bit got;
        int oc;
        cmp_match = 4'b1000;
        send_frame(4, -1);
        exp_drop = exp_drop + 1;
        e = model_decision(cmp_match, m_en, 1'b0);
        model_count(e[EW-2]);
        exp_q.push_back(e);
        send_frame(4, -1);
        wait_decision(got, obs, oc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || obs !== e) begin n_err++; $display("FAIL abort_decision: got %b (seen=%b) required %b", obs, got, e); end
        n_cmp++;
        if (oc - start_cyc != LATENCY) begin n_err++; $display("FAIL abort_latency: got %0d required %0d", oc - start_cyc, LATENCY); end
        wait_idle();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0) begin n_err++; $display("FAIL abort_extra: %0d extra decisions, required 0", obs_q.size()); end
        n_cmp++;
        if ({acc_cnt, drop_cnt} !== {16'(exp_acc), 16'(exp_drop)}) begin
            n_err++; $display("FAIL abort_counters: got %0d/%0d required %0d/%0d", acc_cnt, drop_cnt, exp_acc, exp_drop);
        end
    endtask

    task automatic test_rst_mid_frame();
        cmp_match = 4'b1000;
        fork
            send_frame(6, -1);
            begin
                repeat (2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        model_reset();
        repeat (12) @(negedge clk);
        n_cmp++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_frame: decisions=%0d busy=%b required 0/0", obs_q.size(), busy); end
        n_cmp++;
        if ({acc_cnt, drop_cnt} !== 32'd0 || cmp_mac !== '0) begin
            n_err++; $display("FAIL rst_mid_state: acc=%0d drop=%0d mac=%h required zeros", acc_cnt, drop_cnt, cmp_mac);
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] e, obs;
        logic [47:0] mac;
        bit got, werr;
        int oc, len, gap;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                mac = {16'($urandom()), $urandom()};
                cfg_write(int'($urandom_range(0, NUM_MACS - 1)), mac, 1'($urandom_range(0, 1)));
            end
            cmp_match = NUM_MACS'($urandom_range(0, 15));
            len = int'($urandom_range(1, 8));
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, len)) : -1;
            werr = model_werr(len, gap);
            e = model_decision(cmp_match, m_en, werr);
            model_count(e[EW-2]);
            exp_q.push_back(e);
            send_frame(len, gap);
            wait_decision(got, obs, oc);
            e = exp_q.pop_front();
            n_cmp++;
            if (!got || obs !== e) begin
                n_err++; $display("FAIL random_%0d: len=%0d gap=%0d match=%b got %b (seen=%b) required %b", k, len, gap, cmp_match, obs, got, e);
            end
            n_cmp++;
            if ({acc_cnt, drop_cnt} !== {16'(exp_acc), 16'(exp_drop)}) begin
                n_err++; $display("FAIL random_cnt_%0d: got %0d/%0d required %0d/%0d", k, acc_cnt, drop_cnt, exp_acc, exp_drop);
            end
            wait_idle();
        end
    endtask

    task automatic test_saturation();
        logic [EW-1:0] e, obs;
        bit got;
        int oc;
        cfg_write(1, 48'h0011_2233_4455, 1'b1);
        cmp_match = 4'b0010;
        force dut.acc_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.acc_cnt;
        exp_acc = 65534;
        for (int f = 0; f < 2; f++) begin
            e = model_decision(cmp_match, m_en, 1'b0);
            model_count(e[EW-2]);
            send_frame(4, -1);
            wait_decision(got, obs, oc);
            n_cmp++;
            if (acc_cnt !== 16'(exp_acc)) begin n_err++; $display("FAIL saturate_%0d: got %h required %h", f, acc_cnt, 16'(exp_acc)); end
            wait_idle();
        end
        fork
            send_frame(4, -1);
            begin
                repeat (LATENCY - 1) @(negedge clk);
                stat_clr = 1'b1;
                @(negedge clk);
                stat_clr = 1'b0;
            end
        join
        exp_acc = 0;
        exp_drop = 0;
        wait_decision(got, obs, oc);
        n_cmp++;
        if (!got) begin n_err++; $display("FAIL stat_clr_decision: no decision, required one"); end
        n_cmp++;
        if ({acc_cnt, drop_cnt} !== {16'(exp_acc), 16'(exp_drop)}) begin
            n_err++; $display("FAIL stat_clr_priority: got %0d/%0d required %0d/%0d", acc_cnt, drop_cnt, exp_acc, exp_drop);
        end
        wait_idle();
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_mac = '0; cfg_en = 1'b0;
        frame_start = 1'b0; data_valid = 1'b0; frame_end = 1'b0; data_in = '0;
        cmp_match = '0; stat_clr = 1'b0;
        test_reset();
        test_hit();
        test_priority();
        test_window_break();
        test_snapshot();
        test_abort();
        test_rst_mid_frame();
        test_random();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
